// File: rtl/network_mac_fxp_pipe.sv
// Three-stage fixed-point multiply-accumulate: product register, group accumulator,
// and a rounded/saturated output register behind a valid/ready handshake.
module network_mac_fxp_pipe #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_LEN    = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         dout_sat,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int PW     = din0_WIDTH + din1_WIDTH;
  localparam int AW     = PW + $clog2(ACC_LEN) + 1;
  localparam int RW     = AW + 1;
  localparam int CW     = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

  localparam logic [CW-1:0]               LAST = CW'(ACC_LEN - 1);
  localparam logic signed [RW-1:0]        RND  = (FRAC_BITS > 0) ? (RW'(1) <<< RND_SH) : '0;
  localparam logic signed [dout_WIDTH-1:0] OMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [dout_WIDTH-1:0] OMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
  localparam logic signed [RW-1:0]        RMAX = RW'(OMAX);
  localparam logic signed [RW-1:0]        RMIN = RW'(OMIN);

  logic                         v1_q, v1_d;
  logic signed [PW-1:0]         p1_q, p1_d;
  logic signed [AW-1:0]         acc_q, acc_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         done_q, done_d;
  logic signed [dout_WIDTH-1:0] dout_q, dout_d;
  logic                         sat_q, sat_d;
  logic                         out_valid_q, out_valid_d;

  logic                         adv;
  logic signed [AW-1:0]         p1_ext;
  logic signed [RW-1:0]         rounded;

  // NOTE: combinational next-state logic uses blocking '=' with every _d defaulted
  // to its _q first, so no path can infer a latch; only always_ff uses '<='.
  always_comb begin
    in_ready    = ~out_valid_q | out_ready;
    adv         = ce & in_ready;
    p1_ext      = AW'(p1_q);
    rounded     = (RW'(acc_q) + RND) >>> FRAC_BITS;

    v1_d        = v1_q;
    p1_d        = p1_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    dout_d      = dout_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    if (adv) begin
      v1_d   = in_valid;
      p1_d   = PW'(din0) * PW'(din1);
      done_d = v1_q && (cnt_q == LAST);
      if (v1_q) begin
        acc_d = (cnt_q == '0) ? p1_ext : acc_q + p1_ext;
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
      // acc_q still holds the finished group here even if a new group loads it now.
      out_valid_d = done_q;
      if (done_q) begin
        if (rounded > RMAX) begin
          dout_d = OMAX;
          sat_d  = 1'b1;
        end else if (rounded < RMIN) begin
          dout_d = OMIN;
          sat_d  = 1'b1;
        end else begin
          dout_d = rounded[dout_WIDTH-1:0];
          sat_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: the product register is pure datapath qualified by v1_q, so it carries
  // no reset.
  always_ff @(posedge clk) begin
    p1_q <= p1_d;
  end

  assign dout      = dout_q;
  assign dout_sat  = sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_network_mac_fxp_pipe.sv
// Scoreboard bench for network_mac_fxp_pipe at default parameters: a reference model
// queues expected results on acceptance; a monitor checks them on each output handshake.
module tb_network_mac_fxp_pipe;

  typedef struct {
    longint d;
    bit     s;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ce = 1'b1;
  logic signed [15:0] din0 = '0;
  logic signed [15:0] din1 = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] dout;
  logic               dout_sat;
  logic               out_valid;
  logic               out_ready = 1'b1;

  int     total = 0;
  int     bad = 0;
  exp_t   sb[$];
  longint m_acc = 0;
  int     m_cnt = 0;
  longint last_d = 0;
  bit     stall_done = 0;

  network_mac_fxp_pipe #(
    .ID(1), .din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(16), .FRAC_BITS(8), .ACC_LEN(9)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .dout_sat(dout_sat),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: group sum, round half up at bit 7, arithmetic shift by 8, clamp to 16 bits.
  task automatic model_accept(input int a, input int b);
    longint p;
    exp_t   e;
    p     = longint'(a) * longint'(b);
    m_acc = (m_cnt == 0) ? p : m_acc + p;
    m_cnt++;
    if (m_cnt == 9) begin
      longint r;
      m_cnt = 0;
      r = (m_acc + 128) >>> 8;
      if (r > 32767)       begin e.d = 32767;  e.s = 1; end
      else if (r < -32768) begin e.d = -32768; e.s = 1; end
      else                 begin e.d = r;      e.s = 0; end
      sb.push_back(e);
    end
  endtask

  task automatic send_pair(input int a, input int b);
    int n = 0;
    bit acc = 0;
    din0     = 16'(a);
    din1     = 16'(b);
    in_valid = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clk);
      if (in_ready && ce) acc = 1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc) model_accept(a, b);
    else check("accept_timeout", 0, 1);
  endtask

  task automatic send_group(input int a, input int b);
    for (int i = 0; i < 9; i++) send_pair(a, b);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_dout", dout, 0);
    check("rst_sat", dout_sat, 0);
    last_d = 0;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && ce) begin
      if (sb.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dout", longint'(dout), e.d);
        check("dout_sat", dout_sat, e.s);
        last_d = e.d;
      end
    end
  end

  initial begin
    exp_t e;
    int   n;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Nominal group and exact output latency.
    for (int i = 0; i < 8; i++) send_pair(256, 256);
    send_pair(256, 256);
    @(negedge clk);
    check("lat_edge0", out_valid, 0);
    @(negedge clk);
    check("lat_edge1", out_valid, 0);
    @(negedge clk);
    check("lat_edge2", out_valid, 1);
    check("lat_dout", dout, 2304);
    wait_drain();

    // Saturation both ways and rounding both signs, back to back.
    send_group(32767, 32767);
    send_group(-32768, 32767);
    send_pair(3, 43);
    for (int i = 0; i < 8; i++) send_pair(0, 0);
    send_pair(-1, 129);
    for (int i = 0; i < 8; i++) send_pair(0, 0);
    wait_drain();

    // Backpressure: stall 10 cycles with later pairs already in flight.
    out_ready  = 1'b0;
    stall_done = 0;
    fork
      begin
        send_group(100, -30);
        for (int i = 0; i < 9; i++) send_pair(int'($urandom_range(0, 400)) - 200, 77 - i);
      end
      begin
        n = 0;
        while (!out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("stall_seen", out_valid, 1);
        e = sb[0];
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_valid", out_valid, 1);
          check("stall_dout", longint'(dout), e.d);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Clock enable low mid-group with a pair offered: nothing may move.
    for (int i = 0; i < 4; i++) send_pair(200, 50);
    din0     = 16'sd200;
    din1     = 16'sd50;
    in_valid = 1'b1;
    ce       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ce_valid", out_valid, 0);
      check("ce_dout", longint'(dout), last_d);
      @(posedge clk);
      #1;
    end
    ce = 1'b1;
    for (int i = 0; i < 5; i++) send_pair(200, 50);
    check("ce_expected", sb[0].d, 352);
    wait_drain();

    // Reset discards a partial group.
    for (int i = 0; i < 5; i++) send_pair(100, 100);
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    send_group(1, 256);
    check("rst_group_expected", sb[0].d, 9);
    wait_drain();

    // Random operands with random consumer backpressure.
    stall_done = 0;
    fork
      begin
        for (int i = 0; i < 27; i++)
          send_pair(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 4000)) - 2000);
        stall_done = 1;
      end
      begin
        while (!stall_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    repeat (5) @(posedge clk);
    #1;
    check("no_extra_out", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
